calendar_counter: RTL and testbench
===================================

CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Parameters, one per line (name, default, meaning):
- YEAR_W, 12: year register width; legal range 8..16.
- RESET_YEAR, 2000: year value loaded on reset; must be less than 2^YEAR_W.
- LEAP_MODE, 1: 0 = every year divisible by 4 is leap; 1 = full Gregorian rule (divisible by 4, and not by 100 unless divisible by 400).
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- tick, in, 1: advance the date by one day.
- load, in, 1: write the load_* values.
- load_day, in, 5: day to load.
- load_month, in, 4: month to load.
- load_year, in, YEAR_W: year to load.
- day, out, 5: current day, 1..31.
- month, out, 4: current month, 1..12.
- year, out, YEAR_W: current year.
- month_type, out, 2: 00 = 30-day month, 01 = 31-day month, 10 = February; 11 is never driven.
- leap, out, 1: current year is a leap year.
- month_end, out, 1: one-cycle pulse on a month rollover.
- year_end, out, 1: one-cycle pulse on a year rollover.
- year_wrap, out, 1: one-cycle pulse when the year overflows to 0.
- error, out, 1: the last load was rejected.

Function
REQ-004 day, month, year, month_end, year_end, year_wrap and error SHALL be registered; month_type and leap SHALL be combinational decodes of the registered month and year.
REQ-005 Days-in-month (dim) SHALL be: 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11; 29 for February when leap=1, else 28.
REQ-006 leap SHALL follow LEAP_MODE exactly; year 0 SHALL count as leap in both modes.
REQ-007 On tick=1 with load=0, the registers SHALL update at the next rising edge (latency 1 cycle):
- day < dim: day+1.
- day = dim and month < 12: day=1, month+1, month_end=1.
- day = dim and month = 12: day=1, month=1, year+1, month_end=1, year_end=1.
REQ-008 Year increment SHALL wrap modulo 2^YEAR_W; when the year goes from 2^YEAR_W-1 to 0, year_wrap=1 in the same cycle as year_end.
REQ-009 month_end, year_end and year_wrap SHALL be high for exactly one cycle, coincident with the updated date; otherwise they are 0.
REQ-010 A load is valid when 1 <= load_month <= 12 and 1 <= load_day <= dim(load_month, load_year), with dim computed from the load values.
- Valid load: day/month/year take the load values next cycle; error=0.
- Invalid load: day/month/year are unchanged; error=1.
REQ-011 error SHALL be sticky: it holds until the next valid load or reset, and tick does not clear it.
REQ-012 When load=1 and tick=1 in the same cycle, load SHALL take priority; the tick is dropped and no pulses are issued.
REQ-013 A load SHALL never assert month_end, year_end or year_wrap.
REQ-014 tick with load=0 SHALL operate normally while error=1, because the stored date is always valid.
REQ-015 The stored date SHALL never leave the valid set: day 1..dim, month 1..12.

Reset
REQ-016 On rst=1 at a rising edge, the block SHALL set day=1, month=1, year=RESET_YEAR, error=0 and all pulses=0.
REQ-017 rst SHALL take priority over load and tick, including mid-rollover; there are no partial updates.
REQ-018 After reset, month_type=01, and leap reflects RESET_YEAR (1 for 2000).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Non-leap February: LEAP_MODE=1, load 28/2/2023, tick -> 1/3/2023, month_end=1, leap=0.
- Leap February: load 28/2/2024, tick -> 29/2/2024 with no pulse; tick -> 1/3/2024, month_end=1.
- Century rule: year 1900 -> LEAP_MODE=1 gives leap=0 and 28/2 -> 1/3; LEAP_MODE=0 gives leap=1 and 28/2 -> 29/2. Year 2000 -> leap=1 in both modes.
- Year and wrap rollover: load 31/12/2023, tick -> 1/1/2024 with month_end=year_end=1 for one cycle. With YEAR_W=8, load 31/12/255, tick -> 1/1/0 with year_wrap=1.
- Invalid loads: each of 31/4/2023, 29/2/2023, 0/5/2023, 10/13/2023 -> error=1, date unchanged. A following tick advances normally with error still 1. A valid load of 1/1/2023 -> error=0.
- Priority: load 15/6/2023 with tick=1 in the same cycle -> 15/6/2023 and no pulse. rst asserted together with load and tick on 31/12 -> 1/1/RESET_YEAR, error=0, all pulses 0.

Source files
------------

// File: rtl/calendar_counter.sv
// calendar_counter
// Day/month/year calendar register with tick-driven advance, validated load,
// and one-cycle rollover pulses.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   tick         advance the stored date by one day
//   load         write load_day/load_month/load_year (checked for validity)
//   load_day     day to load (1..31)
//   load_month   month to load (1..12)
//   load_year    year to load
//   day          current day (registered)
//   month        current month (registered)
//   year         current year (registered)
//   month_type   00 = 30-day, 01 = 31-day, 10 = February (combinational)
//   leap         current year is a leap year (combinational)
//   month_end    one-cycle pulse on month rollover
//   year_end     one-cycle pulse on year rollover
//   year_wrap    one-cycle pulse when the year overflows to 0
//   error        sticky: last load was rejected
module calendar_counter #(
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2000,
    parameter int LEAP_MODE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [1:0]        month_type,
    output logic              leap,
    output logic              month_end,
    output logic              year_end,
    output logic              year_wrap,
    output logic              error
);

    // Year 0 is divisible by 400, so it is leap under either rule.
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned yi;
        yi = {{(32-YEAR_W){1'b0}}, y};
        if (LEAP_MODE == 0) begin
            return (yi % 4) == 0;
        end
        return ((yi % 4) == 0) && (((yi % 100) != 0) || ((yi % 400) == 0));
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    logic [4:0] cur_dim;
    logic       load_valid;

    assign leap    = is_leap(year);
    assign cur_dim = days_in(month, leap);

    always_comb begin
        case (month)
            4'd2:                    month_type = 2'b10;
            4'd4, 4'd6, 4'd9, 4'd11: month_type = 2'b00;
            default:                 month_type = 2'b01;
        endcase
    end

    // days_in() returns 31 for out-of-range months, but those are already
    // rejected by the month range check.
    assign load_valid = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                        (load_day >= 5'd1) &&
                        (load_day <= days_in(load_month, is_leap(load_year)));

    always_ff @(posedge clk) begin
        if (rst) begin
            day       <= 5'd1;
            month     <= 4'd1;
            year      <= YEAR_W'(RESET_YEAR);
            month_end <= 1'b0;
            year_end  <= 1'b0;
            year_wrap <= 1'b0;
            error     <= 1'b0;
        end else begin
            month_end <= 1'b0;
            year_end  <= 1'b0;
            year_wrap <= 1'b0;
            if (load) begin
                // Load wins over tick; a dropped tick produces no pulse.
                if (load_valid) begin
                    day   <= load_day;
                    month <= load_month;
                    year  <= load_year;
                    error <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end else if (tick) begin
                if (day < cur_dim) begin
                    day <= day + 5'd1;
                end else begin
                    day       <= 5'd1;
                    month_end <= 1'b1;
                    if (month < 4'd12) begin
                        month <= month + 4'd1;
                    end else begin
                        month    <= 4'd1;
                        year     <= year + 1'b1;
                        year_end <= 1'b1;
                        year_wrap <= (year == {YEAR_W{1'b1}});
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
module tb_calendar_counter;

    logic        clk = 1'b0;
    logic        rst, tick, load;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [11:0] load_year;
    logic [7:0]  load_year8;

    // Main instance: YEAR_W=12, Gregorian rule
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [1:0]  month_type;
    logic        leap, month_end, year_end, year_wrap, error;

    // Divisible-by-4 rule instance
    logic [4:0]  d0_day;
    logic [3:0]  d0_month;
    logic [11:0] d0_year;
    logic [1:0]  d0_month_type;
    logic        d0_leap, d0_month_end, d0_year_end, d0_year_wrap, d0_error;

    // 8-bit year instance
    logic [4:0]  w_day;
    logic [3:0]  w_month;
    logic [7:0]  w_year;
    logic [1:0]  w_month_type;
    logic        w_leap, w_month_end, w_year_end, w_year_wrap, w_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calendar_counter #(.YEAR_W(12), .RESET_YEAR(2000), .LEAP_MODE(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .day(day), .month(month), .year(year), .month_type(month_type),
        .leap(leap), .month_end(month_end), .year_end(year_end),
        .year_wrap(year_wrap), .error(error)
    );

    calendar_counter #(.YEAR_W(12), .RESET_YEAR(2000), .LEAP_MODE(0)) dut_m0 (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .day(d0_day), .month(d0_month), .year(d0_year), .month_type(d0_month_type),
        .leap(d0_leap), .month_end(d0_month_end), .year_end(d0_year_end),
        .year_wrap(d0_year_wrap), .error(d0_error)
    );

    calendar_counter #(.YEAR_W(8), .RESET_YEAR(200), .LEAP_MODE(1)) dut_w8 (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year8),
        .day(w_day), .month(w_month), .year(w_year), .month_type(w_month_type),
        .leap(w_leap), .month_end(w_month_end), .year_end(w_year_end),
        .year_wrap(w_year_wrap), .error(w_error)
    );

    // One clock with the given controls applied, sampled 1 ns after the edge.
    task automatic cycle(input logic r, input logic t, input logic l);
        rst = r; tick = t; load = l;
        @(posedge clk);
        #1;
        rst = 1'b0; tick = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] d, input logic [3:0] m,
                           input logic [11:0] y, input logic [7:0] y8);
        load_day = d; load_month = m; load_year = y; load_year8 = y8;
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if ({day, month, year} !== {5'd1, 4'd1, 12'd2000}) begin
            errors++;
            $display("FAIL reset_date got %0d/%0d/%0d want 1/1/2000", day, month, year);
        end
        checks++;
        if ({month_type, leap, error, month_end, year_end, year_wrap} !== {2'b01, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_flags got mt=%b leap=%b err=%b me=%b ye=%b yw=%b want mt=01 leap=1 rest 0",
                     month_type, leap, error, month_end, year_end, year_wrap);
        end
        checks++;
        if (d0_leap !== 1'b1) begin
            errors++;
            $display("FAIL reset_leap_mode0 got %b want 1", d0_leap);
        end
        checks++;
        if ({w_year, w_leap} !== {8'd200, 1'b0}) begin
            errors++;
            $display("FAIL reset_w8 got year=%0d leap=%b want 200 0", w_year, w_leap);
        end
    endtask

    task automatic test_nonleap_feb;
        do_load(5'd28, 4'd2, 12'd2023, 8'd23);
        checks++;
        if ({month_type, leap, error} !== {2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL feb2023_decode got mt=%b leap=%b err=%b want 10 0 0", month_type, leap, error);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, year, month_end, year_end} !== {5'd1, 4'd3, 12'd2023, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL feb2023_tick got %0d/%0d/%0d me=%b ye=%b want 1/3/2023 me=1 ye=0",
                     day, month, year, month_end, year_end);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (month_end !== 1'b0) begin
            errors++;
            $display("FAIL feb2023_pulse_width got me=%b want 0", month_end);
        end
    endtask

    task automatic test_leap_feb;
        do_load(5'd28, 4'd2, 12'd2024, 8'd24);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, leap, month_end} !== {5'd29, 4'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL feb2024_29 got %0d/%0d leap=%b me=%b want 29/2 leap=1 me=0",
                     day, month, leap, month_end);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, year, month_end} !== {5'd1, 4'd3, 12'd2024, 1'b1}) begin
            errors++;
            $display("FAIL feb2024_roll got %0d/%0d/%0d me=%b want 1/3/2024 me=1",
                     day, month, year, month_end);
        end
    endtask

    task automatic test_century;
        do_load(5'd28, 4'd2, 12'd1900, 8'd19);
        checks++;
        if ({leap, d0_leap} !== 2'b01) begin
            errors++;
            $display("FAIL century_leap got g=%b m0=%b want 0 1", leap, d0_leap);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month} !== {5'd1, 4'd3}) begin
            errors++;
            $display("FAIL century_greg_tick got %0d/%0d want 1/3", day, month);
        end
        checks++;
        if ({d0_day, d0_month, d0_month_end} !== {5'd29, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL century_mode0_tick got %0d/%0d me=%b want 29/2 me=0",
                     d0_day, d0_month, d0_month_end);
        end
        do_load(5'd29, 4'd2, 12'd2000, 8'd20);
        checks++;
        if ({leap, d0_leap, error, d0_error, day, d0_day} !== {4'b1100, 5'd29, 5'd29}) begin
            errors++;
            $display("FAIL y2000_leap got g=%b m0=%b err=%b/%b day=%0d/%0d want 1 1 0/0 29/29",
                     leap, d0_leap, error, d0_error, day, d0_day);
        end
    endtask

    task automatic test_year_rollover;
        do_load(5'd31, 4'd12, 12'd2023, 8'd255);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, year, month_end, year_end, year_wrap} !== {5'd1, 4'd1, 12'd2024, 3'b110}) begin
            errors++;
            $display("FAIL year_roll got %0d/%0d/%0d me=%b ye=%b yw=%b want 1/1/2024 1 1 0",
                     day, month, year, month_end, year_end, year_wrap);
        end
        checks++;
        if ({w_day, w_month, w_year, w_month_end, w_year_end, w_year_wrap, w_leap} !==
            {5'd1, 4'd1, 8'd0, 4'b1111}) begin
            errors++;
            $display("FAIL year_wrap8 got %0d/%0d/%0d me=%b ye=%b yw=%b leap=%b want 1/1/0 1 1 1 1",
                     w_day, w_month, w_year, w_month_end, w_year_end, w_year_wrap, w_leap);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({month_end, year_end, w_month_end, w_year_end, w_year_wrap} !== 5'b0) begin
            errors++;
            $display("FAIL year_pulse_width got %b%b%b%b%b want 00000",
                     month_end, year_end, w_month_end, w_year_end, w_year_wrap);
        end
    endtask

    task automatic test_invalid_load;
        logic [4:0]  bad_d [4] = '{5'd31, 5'd29, 5'd0, 5'd10};
        logic [3:0]  bad_m [4] = '{4'd4,  4'd2,  4'd5, 4'd13};
        do_load(5'd15, 4'd3, 12'd2023, 8'd23);
        for (int i = 0; i < 4; i++) begin
            do_load(bad_d[i], bad_m[i], 12'd2023, 8'd23);
            checks++;
            if ({error, day, month, year} !== {1'b1, 5'd15, 4'd3, 12'd2023}) begin
                errors++;
                $display("FAIL invalid_load_%0d got err=%b %0d/%0d/%0d want err=1 15/3/2023",
                         i, error, day, month, year);
            end
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({error, day, month} !== {1'b1, 5'd16, 4'd3}) begin
            errors++;
            $display("FAIL tick_while_error got err=%b %0d/%0d want err=1 16/3", error, day, month);
        end
        do_load(5'd1, 4'd1, 12'd2023, 8'd23);
        checks++;
        if ({error, day, month, year} !== {1'b0, 5'd1, 4'd1, 12'd2023}) begin
            errors++;
            $display("FAIL error_clear got err=%b %0d/%0d/%0d want err=0 1/1/2023",
                     error, day, month, year);
        end
    endtask

    task automatic test_back_to_back;
        do_load(5'd29, 4'd4, 12'd2023, 8'd23);
        checks++;
        if (month_type !== 2'b00) begin
            errors++;
            $display("FAIL april_type got %b want 00", month_type);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, month_end} !== {5'd1, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL b2b_april got %0d/%0d me=%b want 1/5 me=1", day, month, month_end);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({day, month, month_end} !== {5'd2, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL b2b_next got %0d/%0d me=%b want 2/5 me=0", day, month, month_end);
        end
    endtask

    task automatic test_priority;
        do_load(5'd30, 4'd6, 12'd2023, 8'd23);
        load_day = 5'd15; load_month = 4'd6; load_year = 12'd2023;
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if ({day, month, year, month_end, year_end, year_wrap} !== {5'd15, 4'd6, 12'd2023, 3'b000}) begin
            errors++;
            $display("FAIL load_over_tick got %0d/%0d/%0d pulses=%b%b%b want 15/6/2023 000",
                     day, month, year, month_end, year_end, year_wrap);
        end
        do_load(5'd31, 4'd12, 12'd2023, 8'd255);
        do_load(5'd31, 4'd11, 12'd2023, 8'd255);
        load_day = 5'd31; load_month = 4'd12; load_year = 12'd2023; load_year8 = 8'd255;
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if ({day, month, year, error, month_end, year_end, year_wrap} !==
            {5'd1, 4'd1, 12'd2000, 4'b0000}) begin
            errors++;
            $display("FAIL rst_priority got %0d/%0d/%0d err=%b pulses=%b%b%b want 1/1/2000 0 000",
                     day, month, year, error, month_end, year_end, year_wrap);
        end
        checks++;
        if ({w_day, w_month, w_year, w_year_wrap} !== {5'd1, 4'd1, 8'd200, 1'b0}) begin
            errors++;
            $display("FAIL rst_priority_w8 got %0d/%0d/%0d yw=%b want 1/1/200 0",
                     w_day, w_month, w_year, w_year_wrap);
        end
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; load = 1'b0;
        load_day = 5'd1; load_month = 4'd1; load_year = 12'd0; load_year8 = 8'd0;
        #2;
        test_reset;
        test_nonleap_feb;
        test_leap_feb;
        test_century;
        test_year_rollover;
        test_invalid_load;
        test_back_to_back;
        test_priority;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
